rs232_des: RTL and testbench

RS232_DES -- requirements
Module: rs232_des

---
 rtl/rs232_pkg.sv | 14 +
 rtl/rs232_bit_timer.sv | 34 +++
 rtl/rs232_des.sv | 127 ++++++++++++
 tb/tb_rs232_des.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared types and timing helpers for the inverted-polarity RS232 deserializer.
package rs232_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rs232_state_t;

  localparam int unsigned DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned DEF_BAUD_RATE   = 9600;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq_hz,
                                               input int unsigned baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/rs232_bit_timer.sv
// Baud counter: cleared by the FSM, flags the half-bit and full-bit points.
module rs232_bit_timer
  import rs232_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ_HZ, DEF_BAUD_RATE)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int unsigned CW = ($clog2(CLKS_PER_BIT + 1) > 16) ? $clog2(CLKS_PER_BIT + 1) : 16;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Saturates rather than wraps so a long break cannot fake a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign half_tick = (cnt == HALF_M1);
  assign full_tick = (cnt == FULL_M1);

endmodule

// File: rtl/rs232_des.sv
// Inverted-polarity RS232 receiver with level request / acknowledge handshake.
// Define RS232_DES_SYNC_EN to insert a 2-flop synchronizer on rx.
module rs232_des
  import rs232_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned BAUD_RATE   = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_req,
  input  logic       rx_ack
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

  logic rx_s;

`ifdef RS232_DES_SYNC_EN
  logic [1:0] rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
    end
  end

  assign rx_s = rx_sync[1];
`else
  assign rx_s = rx;
`endif

  rs232_state_t state;
  logic [2:0]   bit_idx;
  logic [7:0]   shreg;
  logic         dlv;
  logic         brk;
  logic         tmr_clr;
  logic         half_tick;
  logic         full_tick;

  rs232_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  // Counter restarts at every sample point so the next tick lands mid-bit.
  always_comb begin
    tmr_clr = 1'b0;
    case (state)
      IDLE:    tmr_clr = 1'b1;
      START:   tmr_clr = half_tick;
      DATA:    tmr_clr = full_tick;
      default: tmr_clr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      dlv     <= 1'b0;
      brk     <= 1'b0;
      rx_data <= '0;
      rx_req  <= 1'b0;
    end else begin
      dlv <= 1'b0;

      // A delivery overrides a coincident ack; an unacked pending byte blocks it.
      if (dlv) begin
        if (!rx_req || rx_ack) begin
          rx_data <= shreg;
          rx_req  <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_req <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_s) state <= START;
        end
        START: begin
          if (half_tick) begin
            if (rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (full_tick) begin
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              dlv   <= 1'b1;
              brk   <= 1'b0;
            end
          end
        end
        STOP: begin
          if (brk) begin
            if (!rx_s) state <= IDLE;
          end else if (full_tick) begin
            if (rx_s) brk <= 1'b1;
            else      state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_des.sv
// Scoreboard bench for rs232_des: random framed bytes versus a byte-level model.
module tb_rs232_des;

  localparam int unsigned CLK_FREQ = 100_000_000;
  localparam int unsigned BAUD     = 6_250_000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_req;
  logic       rx_ack = 1'b0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         auto_ack = 1'b0;
  bit         man_ack = 1'b0;
  bit         req_model = 1'b0;

  rs232_des #(
    .CLK_FREQ_HZ(CLK_FREQ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .rx_data(rx_data),
    .rx_req (rx_req),
    .rx_ack (rx_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Byte-level model: a byte is presented unless an earlier one is still pending.
  task automatic model_frame(input logic [7:0] b);
    if (!req_model) begin
      exp_q.push_back(b);
      req_model = !auto_ack;
    end
  endtask

  task automatic hold(input logic v, input int unsigned n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int unsigned stop_len,
                            input int unsigned brk_len);
    model_frame(b);
    hold(1'b1, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    if (!auto_ack) chk("req_before_stop", {7'd0, rx_req}, 8'd1);
    if (brk_len > 0) hold(1'b1, brk_len);
    hold(1'b0, stop_len);
  endtask

  task automatic do_ack();
    man_ack = 1'b1;
    for (int i = 0; i < 4 && man_ack; i++) @(posedge clk);
    #1;
    if (man_ack) begin
      checks++;
      errors++;
      $display("FAIL ack_issue actual=pending required=issued");
      man_ack = 1'b0;
    end
    req_model = 1'b0;
  endtask

  // Monitor: compares on each new request and drives the acknowledge.
  initial begin
    logic       prev_req;
    logic       ack_prev;
    logic       ack_now;
    logic [7:0] exp;
    prev_req = 1'b0;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_prev && prev_req) chk("ack_clears_req", {7'd0, rx_req}, 8'd0);
      ack_now = 1'b0;
      if (rx_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual=%h required=none", rx_data);
        end else begin
          exp = exp_q.pop_front();
          chk("rx_data", rx_data, exp);
        end
        if (auto_ack) ack_now = 1'b1;
      end
      if (man_ack) begin
        ack_now = 1'b1;
        man_ack = 1'b0;
      end
      rx_ack   = ack_now;
      ack_prev = ack_now;
      prev_req = rx_req;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  b;
    int unsigned brk_len;
    int unsigned stop_len;

    rst_n = 1'b0;
    rx    = 1'b1;
    #40;
    chk("reset_data_rx1", rx_data, 8'h00);
    chk("reset_req_rx1", {7'd0, rx_req}, 8'd0);
    rx = 1'b0;
    #60;
    chk("reset_data", rx_data, 8'h00);
    chk("reset_req", {7'd0, rx_req}, 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    hold(1'b0, 50);
    chk("idle_no_req", {7'd0, rx_req}, 8'd0);

    send_frame(8'hAA, CPB, 0);
    do_ack();
    chk("ack_req_low", {7'd0, rx_req}, 8'd0);
    chk("ack_data_hold", rx_data, 8'hAA);

    hold(1'b0, CPB);
    send_frame(8'h55, CPB, 0);
    chk("data_55", rx_data, 8'h55);
    do_ack();
    do_ack();
    chk("ack_ignored_req", {7'd0, rx_req}, 8'd0);
    chk("ack_ignored_data", rx_data, 8'h55);

    hold(1'b1, 3);
    hold(1'b0, 4 * CPB);
    chk("glitch_no_req", {7'd0, rx_req}, 8'd0);

    send_frame(8'h12, CPB, 0);
    send_frame(8'h34, 2 * CPB, 0);
    chk("overrun_data", rx_data, 8'h12);
    chk("overrun_req", {7'd0, rx_req}, 8'd1);
    do_ack();
    chk("overrun_ack_req", {7'd0, rx_req}, 8'd0);
    send_frame(8'h56, CPB, 0);
    chk("after_overrun_data", rx_data, 8'h56);
    do_ack();

    send_frame(8'hC3, CPB, 3 * CPB);
    do_ack();

    auto_ack = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b        = 8'($urandom);
      brk_len  = ($urandom_range(0, 7) == 0) ? $urandom_range(CPB, 3 * CPB) : 0;
      stop_len = CPB + $urandom_range(0, 2 * CPB);
      send_frame(b, stop_len, brk_len);
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
